// File: rtl/johnson_decoder_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : johnson_decoder_monitor                                    |
// | Description : Samples a Johnson code, decodes it to a state index,       |
// |               tracks step direction and flags illegal codes / sequence   |
// |               errors with a saturating error counter.                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module johnson_decoder_monitor #(
   parameter int WIDTH = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             en,
   input  logic                             clr_err,
   input  logic [WIDTH-1:0]                 jc_in,
   output logic [$clog2(2*WIDTH)-1:0]       idx,
   output logic                             idx_valid,
   output logic                             locked,
   output logic                             dir_down,
   output logic                             step_pulse,
   output logic                             wrap_pulse,
   output logic                             illegal_pulse,
   output logic                             seq_err_pulse,
   output logic [7:0]                       err_count
);

   localparam int IDXW = $clog2(2*WIDTH);
   localparam int c_NSTATES = 2*WIDTH;
   localparam logic [IDXW-1:0] c_LAST_IDX = IDXW'(2*WIDTH-1);

   typedef enum logic [1:0] {
      S_SEARCH  = 2'd0,
      S_ACQUIRE = 2'd1,
      S_LOCKED  = 2'd2
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [IDXW-1:0] r_idx, w_idx_nxt;
   logic            r_idx_valid, w_idx_valid_nxt;
   logic            r_dir_down, w_dir_down_nxt;
   logic            r_step, w_step_nxt;
   logic            r_wrap, w_wrap_nxt;
   logic            r_illegal, w_illegal_nxt;
   logic            r_seq_err, w_seq_err_nxt;
   logic [7:0]      r_err_count, w_err_count_nxt;

   logic            w_legal;
   logic [IDXW-1:0] w_dec;
   logic [IDXW-1:0] w_idx_up, w_idx_down;
   logic            w_is_hold, w_is_up, w_is_down;

   // Johnson code for index k: k LSBs set for k<=W, else (k-W) LSBs clear
   function automatic logic [WIDTH-1:0] code_of(input int k);
      logic [WIDTH-1:0] c;
      for (int b = 0; b < WIDTH; b++) begin
         c[b] = (k <= WIDTH) ? (b < k) : (b >= k - WIDTH);
      end
      return c;
   endfunction

   // Decode the incoming code by matching against every legal pattern
   always_comb begin
      w_legal = 1'b0;
      w_dec   = '0;
      for (int k = 0; k < c_NSTATES; k++) begin
         if (jc_in == code_of(k)) begin
            w_legal = 1'b1;
            w_dec   = IDXW'(k);
         end
      end
   end

   // Neighbours of the last index, with explicit modulo-2W wrap
   always_comb begin
      w_idx_up   = (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;
      w_idx_down = (r_idx == '0) ? c_LAST_IDX : r_idx - 1'b1;
      w_is_hold  = (w_dec == r_idx);
      w_is_up    = (w_dec == w_idx_up);
      w_is_down  = (w_dec == w_idx_down);
   end

   // Next-state, next-output and error-count logic for one enabled sample
   always_comb begin
      w_state_nxt     = r_state;
      w_idx_nxt       = r_idx;
      w_idx_valid_nxt = r_idx_valid;
      w_dir_down_nxt  = r_dir_down;
      w_step_nxt      = 1'b0;
      w_wrap_nxt      = 1'b0;
      w_illegal_nxt   = 1'b0;
      w_seq_err_nxt   = 1'b0;
      if (en) begin
         if (!w_legal) begin
            // idx keeps the last legal value; only validity drops
            w_illegal_nxt   = 1'b1;
            w_idx_valid_nxt = 1'b0;
            w_state_nxt     = S_SEARCH;
         end else begin
            w_idx_nxt       = w_dec;
            w_idx_valid_nxt = 1'b1;
            case (r_state)
               S_SEARCH: begin
                  w_state_nxt = S_ACQUIRE;
               end
               S_ACQUIRE: begin
                  if (w_is_hold) begin
                     w_state_nxt = S_ACQUIRE;
                  end else if (w_is_up) begin
                     w_dir_down_nxt = 1'b0;
                     w_state_nxt    = S_LOCKED;
                  end else if (w_is_down) begin
                     w_dir_down_nxt = 1'b1;
                     w_state_nxt    = S_LOCKED;
                  end else begin
                     w_seq_err_nxt = 1'b1;
                  end
               end
               S_LOCKED: begin
                  if (w_is_hold) begin
                     w_state_nxt = S_LOCKED;
                  end else if ((!r_dir_down && w_is_up) || (r_dir_down && w_is_down)) begin
                     w_step_nxt = 1'b1;
                     w_wrap_nxt = r_dir_down ? (r_idx == '0) : (r_idx == c_LAST_IDX);
                  end else begin
                     w_seq_err_nxt = 1'b1;
                     w_state_nxt   = S_ACQUIRE;
                  end
               end
               default: begin
                  w_state_nxt = S_SEARCH;
               end
            endcase
         end
      end

      // Clear wins over a same-cycle error; count sticks at 255
      w_err_count_nxt = r_err_count;
      if (clr_err) begin
         w_err_count_nxt = '0;
      end else if ((w_illegal_nxt || w_seq_err_nxt) && (r_err_count != 8'hFF)) begin
         w_err_count_nxt = r_err_count + 8'd1;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_SEARCH;
         r_idx       <= '0;
         r_idx_valid <= 1'b0;
         r_dir_down  <= 1'b0;
         r_step      <= 1'b0;
         r_wrap      <= 1'b0;
         r_illegal   <= 1'b0;
         r_seq_err   <= 1'b0;
         r_err_count <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_idx       <= w_idx_nxt;
         r_idx_valid <= w_idx_valid_nxt;
         r_dir_down  <= w_dir_down_nxt;
         r_step      <= w_step_nxt;
         r_wrap      <= w_wrap_nxt;
         r_illegal   <= w_illegal_nxt;
         r_seq_err   <= w_seq_err_nxt;
         r_err_count <= w_err_count_nxt;
      end
   end

   assign idx           = r_idx;
   assign idx_valid     = r_idx_valid;
   assign locked        = (r_state == S_LOCKED);
   assign dir_down      = r_dir_down;
   assign step_pulse    = r_step;
   assign wrap_pulse    = r_wrap;
   assign illegal_pulse = r_illegal;
   assign seq_err_pulse = r_seq_err;
   assign err_count     = r_err_count;

endmodule
`default_nettype wire
